// File: rtl/bure_stage_id.sv
`default_nettype none
// ============================================================================
// Module   : bure_stage_id
// Brief    : Bure RV32I decode stage: handshake, decode, register file with
//            writeback bypass, and a registered bundle for execute.
// Revision : 1.0
// ============================================================================
module bure_stage_id #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_fetch_valid,
    output logic                   o_fetch_ready,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic                   i_flush,
    input  logic                   i_ex_ready,
    input  logic                   i_wb_en,
    input  logic [4:0]             i_wb_rd,
    input  logic [DATA_WIDTH-1:0]  i_wb_data,
    output logic                   o_decode_valid,
    output logic [DATA_WIDTH-1:0]  o_rs1_data,
    output logic [DATA_WIDTH-1:0]  o_rs2_data,
    output logic [DATA_WIDTH-1:0]  o_imm,
    output logic                   o_use_imm,
    output logic [2:0]             o_funct3,
    output logic [6:0]             o_funct7,
    output logic [4:0]             o_rd,
    output logic                   o_rd_we,
    output logic                   o_illegal
);

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_f7_zero    = 7'h00;
    localparam logic [6:0] c_f7_alt     = 7'h20;

    // Register file; entry 0 is never written and never read
    logic [DATA_WIDTH-1:0] r_regs [32];

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_use_imm;
    logic [2:0]            r_funct3;
    logic [6:0]            r_funct7;
    logic [4:0]            r_rd;
    logic                  r_rd_we;
    logic                  r_illegal;
    logic [4:0]            r_rs1_idx;
    logic [4:0]            r_rs2_idx;
    logic                  r_rs1_live;

    logic [6:0]            w_opcode;
    logic [4:0]            w_rs1_idx;
    logic [4:0]            w_rs2_idx;
    logic [4:0]            w_rd;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic                  w_is_op;
    logic                  w_is_op_imm;
    logic                  w_is_lui;
    logic                  w_op_bad;
    logic                  w_op_imm_bad;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_use_imm;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic                  w_rs1_live;
    logic                  w_rd_we;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic                  w_fetch_ready;
    logic                  w_accept;
    logic                  w_stall;

    assign w_opcode  = i_instr[6:0];
    assign w_rd      = i_instr[11:7];
    assign w_f3      = i_instr[14:12];
    assign w_rs1_idx = i_instr[19:15];
    assign w_rs2_idx = i_instr[24:20];
    assign w_f7      = i_instr[31:25];

    assign w_is_op     = (w_opcode == c_opc_op);
    assign w_is_op_imm = (w_opcode == c_opc_op_imm);
    assign w_is_lui    = (w_opcode == c_opc_lui);

    // Only ADD/SUB and SRL/SRA carry the alternate funct7
    assign w_op_bad = ((w_f7 != c_f7_zero) && (w_f7 != c_f7_alt)) ||
                      ((w_f7 == c_f7_alt) && (w_f3 != 3'b000) && (w_f3 != 3'b101));

    assign w_op_imm_bad = ((w_f3 == 3'b001) && (w_f7 != c_f7_zero)) ||
                          ((w_f3 == 3'b101) && (w_f7 != c_f7_zero) && (w_f7 != c_f7_alt));

    always_comb begin
        w_illegal = 1'b1;
        if (w_is_op) begin
            w_illegal = w_op_bad;
        end else if (w_is_op_imm) begin
            w_illegal = w_op_imm_bad;
        end else if (w_is_lui) begin
            w_illegal = 1'b0;
        end
    end

    // Illegal instructions fall back to the register-register field layout
    always_comb begin
        w_imm      = '0;
        w_use_imm  = 1'b0;
        w_funct3   = w_f3;
        w_funct7   = w_f7;
        w_rs1_live = 1'b1;
        if (!w_illegal && w_is_op_imm) begin
            w_imm     = DATA_WIDTH'($signed(i_instr[31:20]));
            w_use_imm = 1'b1;
            w_funct7  = ((w_f3 == 3'b001) || (w_f3 == 3'b101)) ? w_f7 : 7'd0;
        end else if (!w_illegal && w_is_lui) begin
            w_imm      = DATA_WIDTH'($signed({i_instr[31:12], 12'b0}));
            w_use_imm  = 1'b1;
            w_funct3   = 3'b000;
            w_funct7   = 7'd0;
            w_rs1_live = 1'b0;
        end
    end

    assign w_rd_we = !w_illegal && (w_rd != 5'd0);

    always_comb begin
        w_rs1_data = '0;
        if (w_rs1_live && (w_rs1_idx != 5'd0)) begin
            w_rs1_data = (i_wb_en && (i_wb_rd == w_rs1_idx)) ? i_wb_data : r_regs[w_rs1_idx];
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if (w_rs2_idx != 5'd0) begin
            w_rs2_data = (i_wb_en && (i_wb_rd == w_rs2_idx)) ? i_wb_data : r_regs[w_rs2_idx];
        end
    end

    assign w_fetch_ready = !r_valid || i_ex_ready;
    assign w_accept      = i_fetch_valid && w_fetch_ready && !i_flush;
    assign w_stall       = r_valid && !i_ex_ready;

    // Register contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (i_wb_en && (i_wb_rd != 5'd0)) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid    <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_use_imm  <= 1'b0;
            r_funct3   <= 3'd0;
            r_funct7   <= 7'd0;
            r_rd       <= 5'd0;
            r_rd_we    <= 1'b0;
            r_illegal  <= 1'b0;
            r_rs1_idx  <= 5'd0;
            r_rs2_idx  <= 5'd0;
            r_rs1_live <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_use_imm  <= w_use_imm;
            r_funct3   <= w_funct3;
            r_funct7   <= w_funct7;
            r_rd       <= w_rd;
            r_rd_we    <= w_rd_we;
            r_illegal  <= w_illegal;
            r_rs1_idx  <= w_rs1_idx;
            r_rs2_idx  <= w_rs2_idx;
            r_rs1_live <= w_rs1_live;
        end else if (w_stall) begin
            // Keep held operands current with writebacks that land mid-stall
            if (i_wb_en && r_rs1_live && (r_rs1_idx != 5'd0) && (i_wb_rd == r_rs1_idx)) begin
                r_rs1_data <= i_wb_data;
            end
            if (i_wb_en && (r_rs2_idx != 5'd0) && (i_wb_rd == r_rs2_idx)) begin
                r_rs2_data <= i_wb_data;
            end
        end else if (i_ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_fetch_ready  = w_fetch_ready;
    assign o_decode_valid = r_valid;
    assign o_rs1_data     = r_rs1_data;
    assign o_rs2_data     = r_rs2_data;
    assign o_imm          = r_imm;
    assign o_use_imm      = r_use_imm;
    assign o_funct3       = r_funct3;
    assign o_funct7       = r_funct7;
    assign o_rd           = r_rd;
    assign o_rd_we        = r_rd_we;
    assign o_illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_bure_stage_id.sv
`default_nettype none
// ============================================================================
// Module   : tb_bure_stage_id
// Brief    : Directed self-checking bench for the Bure decode stage.
// Revision : 1.0
// ============================================================================
module tb_bure_stage_id;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_fetch_valid;
    logic        o_fetch_ready;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        i_ex_ready;
    logic        i_wb_en;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_decode_valid;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [31:0] o_imm;
    logic        o_use_imm;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic        o_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    bure_stage_id #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
        .i_instr(i_instr), .i_flush(i_flush), .i_ex_ready(i_ex_ready),
        .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_decode_valid(o_decode_valid), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_use_imm(o_use_imm),
        .o_funct3(o_funct3), .o_funct7(o_funct7), .o_rd(o_rd),
        .o_rd_we(o_rd_we), .o_illegal(o_illegal)
    );

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        i_wb_en = 1'b1; i_wb_rd = rd; i_wb_data = data;
        step();
        i_wb_en = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_fetch_valid = 1'b0; i_instr = '0; i_flush = 1'b0;
        i_ex_ready = 1'b0; i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        step(); step();
        i_rst = 1'b0;
        n_cmp++; if (o_decode_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_decode_valid); end
        n_cmp++; if (o_fetch_ready !== 1'b1) begin n_err++; $display("FAIL reset_fetch_ready: got %b want 1", o_fetch_ready); end
        n_cmp++; if ({o_rs1_data, o_rs2_data, o_imm} !== 96'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", {o_rs1_data, o_rs2_data, o_imm}); end
        n_cmp++; if ({o_use_imm, o_funct3, o_funct7, o_rd, o_rd_we, o_illegal} !== 18'd0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", {o_use_imm, o_funct3, o_funct7, o_rd, o_rd_we, o_illegal}); end
    endtask

    task automatic test_add();
        wb_write(5'd5, 32'h11);
        i_fetch_valid = 1'b1; i_instr = 32'h005281B3; i_ex_ready = 1'b1;
        step();
        i_fetch_valid = 1'b0;
        n_cmp++; if (o_decode_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", o_decode_valid); end
        n_cmp++; if (o_rs1_data !== 32'h11) begin n_err++; $display("FAIL add_rs1: got %h want 11", o_rs1_data); end
        n_cmp++; if (o_rs2_data !== 32'h11) begin n_err++; $display("FAIL add_rs2: got %h want 11", o_rs2_data); end
        n_cmp++; if (o_funct3 !== 3'b000 || o_funct7 !== 7'h00) begin n_err++; $display("FAIL add_funct: got %h/%h want 0/0", o_funct3, o_funct7); end
        n_cmp++; if (o_rd !== 5'd3 || o_rd_we !== 1'b1) begin n_err++; $display("FAIL add_rd: got %0d/%b want 3/1", o_rd, o_rd_we); end
        n_cmp++; if (o_use_imm !== 1'b0 || o_illegal !== 1'b0) begin n_err++; $display("FAIL add_flags: got use_imm %b illegal %b want 0/0", o_use_imm, o_illegal); end
        step();
        n_cmp++; if (o_decode_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", o_decode_valid); end
    endtask

    task automatic test_bypass();
        // addi x1,x0,-1 alongside a writeback to x0
        i_wb_en = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'hDEAD;
        i_fetch_valid = 1'b1; i_instr = 32'hFFF00093;
        step();
        i_wb_en = 1'b0; i_fetch_valid = 1'b0;
        n_cmp++; if (o_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", o_imm); end
        n_cmp++; if (o_rs1_data !== 32'h0) begin n_err++; $display("FAIL addi_rs1_x0: got %h want 0", o_rs1_data); end
        n_cmp++; if (o_use_imm !== 1'b1 || o_rd !== 5'd1 || o_rd_we !== 1'b1) begin n_err++; $display("FAIL addi_ctrl: got %b/%0d/%b want 1/1/1", o_use_imm, o_rd, o_rd_we); end
        n_cmp++; if (o_funct7 !== 7'h00 || o_funct3 !== 3'b000) begin n_err++; $display("FAIL addi_funct: got %h/%h want 0/0", o_funct3, o_funct7); end
        // add x3,x5,x5 with x5 written in the accept cycle
        i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h22;
        i_fetch_valid = 1'b1; i_instr = 32'h005281B3;
        step();
        i_wb_en = 1'b0; i_fetch_valid = 1'b0;
        n_cmp++; if (o_rs1_data !== 32'h22 || o_rs2_data !== 32'h22) begin n_err++; $display("FAIL bypass_rs: got %h/%h want 22/22", o_rs1_data, o_rs2_data); end
        step();
    endtask

    task automatic test_stall();
        wb_write(5'd6, 32'h66);
        wb_write(5'd7, 32'h01);
        i_ex_ready = 1'b0;
        i_fetch_valid = 1'b1; i_instr = 32'h40730233;
        step();
        // Offer a competing instruction that must not be taken while stalled
        i_instr = 32'h00100093;
        n_cmp++; if (o_decode_valid !== 1'b1 || o_fetch_ready !== 1'b0) begin n_err++; $display("FAIL sub_valid_ready: got %b/%b want 1/0", o_decode_valid, o_fetch_ready); end
        n_cmp++; if (o_rs1_data !== 32'h66 || o_rs2_data !== 32'h01) begin n_err++; $display("FAIL sub_operands: got %h/%h want 66/01", o_rs1_data, o_rs2_data); end
        n_cmp++; if (o_funct7 !== 7'h20 || o_funct3 !== 3'b000 || o_rd !== 5'd4) begin n_err++; $display("FAIL sub_fields: got %h/%h/%0d want 20/0/4", o_funct7, o_funct3, o_rd); end
        i_wb_en = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'h55;
        step();
        i_wb_en = 1'b0;
        n_cmp++; if (o_rs2_data !== 32'h55) begin n_err++; $display("FAIL stall_refresh_rs2: got %h want 55", o_rs2_data); end
        n_cmp++; if (o_rs1_data !== 32'h66 || o_funct7 !== 7'h20 || o_rd !== 5'd4 || o_rd_we !== 1'b1 || o_use_imm !== 1'b0) begin n_err++; $display("FAIL stall_hold: got %h/%h/%0d/%b/%b want 66/20/4/1/0", o_rs1_data, o_funct7, o_rd, o_rd_we, o_use_imm); end
        n_cmp++; if (o_fetch_ready !== 1'b0 || o_decode_valid !== 1'b1) begin n_err++; $display("FAIL stall_ready: got %b/%b want 0/1", o_fetch_ready, o_decode_valid); end
        i_fetch_valid = 1'b0; i_ex_ready = 1'b1;
        step();
        n_cmp++; if (o_decode_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", o_decode_valid); end
    endtask

    task automatic test_lui_illegal();
        i_fetch_valid = 1'b1; i_instr = 32'h12345137; i_ex_ready = 1'b0;
        step();
        i_fetch_valid = 1'b0;
        n_cmp++; if (o_imm !== 32'h12345000 || o_rs1_data !== 32'h0) begin n_err++; $display("FAIL lui_imm_rs1: got %h/%h want 12345000/0", o_imm, o_rs1_data); end
        n_cmp++; if (o_use_imm !== 1'b1 || o_rd !== 5'd2 || o_rd_we !== 1'b1 || o_illegal !== 1'b0) begin n_err++; $display("FAIL lui_ctrl: got %b/%0d/%b/%b want 1/2/1/0", o_use_imm, o_rd, o_rd_we, o_illegal); end
        // LUI's rs1 field (x8) is ignored by stall refresh
        i_wb_en = 1'b1; i_wb_rd = 5'd8; i_wb_data = 32'h99;
        step();
        i_wb_en = 1'b0;
        n_cmp++; if (o_rs1_data !== 32'h0) begin n_err++; $display("FAIL lui_no_refresh: got %h want 0", o_rs1_data); end
        i_ex_ready = 1'b1;
        i_fetch_valid = 1'b1; i_instr = 32'h000000F3;
        step();
        i_fetch_valid = 1'b0;
        n_cmp++; if (o_decode_valid !== 1'b1 || o_illegal !== 1'b1 || o_rd_we !== 1'b0) begin n_err++; $display("FAIL sys_illegal: got %b/%b/%b want 1/1/0", o_decode_valid, o_illegal, o_rd_we); end
        // add with funct7=0x01 is unsupported
        i_fetch_valid = 1'b1; i_instr = 32'h025281B3;
        step();
        i_fetch_valid = 1'b0;
        n_cmp++; if (o_illegal !== 1'b1 || o_rd_we !== 1'b0 || o_rd !== 5'd3) begin n_err++; $display("FAIL op_f7_illegal: got %b/%b/%0d want 1/0/3", o_illegal, o_rd_we, o_rd); end
        // srai x1,x1,3 keeps funct7=0x20
        i_fetch_valid = 1'b1; i_instr = 32'h4030D093;
        step();
        i_fetch_valid = 1'b0;
        n_cmp++; if (o_illegal !== 1'b0 || o_funct7 !== 7'h20 || o_funct3 !== 3'b101 || o_imm !== 32'h403) begin n_err++; $display("FAIL srai: got %b/%h/%h/%h want 0/20/5/403", o_illegal, o_funct7, o_funct3, o_imm); end
        step();
    endtask

    task automatic test_flush();
        i_fetch_valid = 1'b1; i_instr = 32'h005281B3; i_ex_ready = 1'b0;
        step();
        n_cmp++; if (o_decode_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", o_decode_valid); end
        i_flush = 1'b1; i_instr = 32'h12345137; i_ex_ready = 1'b1;
        step();
        i_flush = 1'b0; i_fetch_valid = 1'b0;
        n_cmp++; if (o_decode_valid !== 1'b0 || o_fetch_ready !== 1'b1) begin n_err++; $display("FAIL flush_valid: got %b/%b want 0/1", o_decode_valid, o_fetch_ready); end
        step();
        n_cmp++; if (o_decode_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got %b want 0", o_decode_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr;
        i_ex_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            instr = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
            i_fetch_valid = 1'b1; i_instr = instr;
            step();
            n_cmp++; if (o_decode_valid !== 1'b1 || o_rd !== 5'(k) || o_imm !== 32'(k)) begin n_err++; $display("FAIL b2b_%0d: got %b/%0d/%h want 1/%0d/%0d", k, o_decode_valid, o_rd, o_imm, k, k); end
        end
        i_fetch_valid = 1'b0;
        step();
        n_cmp++; if (o_decode_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", o_decode_valid); end
    endtask

    task automatic test_reset_midstall();
        i_fetch_valid = 1'b1; i_instr = 32'hFFF00093; i_ex_ready = 1'b0;
        step();
        i_fetch_valid = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        n_cmp++; if (o_decode_valid !== 1'b0 || o_imm !== 32'h0 || o_rd !== 5'd0) begin n_err++; $display("FAIL midstall_reset: got %b/%h/%0d want 0/0/0", o_decode_valid, o_imm, o_rd); end
        n_cmp++; if (o_fetch_ready !== 1'b1) begin n_err++; $display("FAIL midstall_ready: got %b want 1", o_fetch_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bypass();
        test_stall();
        test_lui_illegal();
        test_flush();
        test_back_to_back();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
